// File: rtl/slot_alloc_sched_pkg.sv
// Shared constants, thermometer free-count type and count helpers for the
// 16-entry slot allocation scheduler.
package slot_alloc_sched_pkg;

  localparam int N_ENTRY   = 16;
  localparam int MAX_ALLOC = 4;
  localparam int PTR_W     = 4;

  // Bit k is set when at least k slots are free.
  typedef logic [16:1] free_therm_t;

  function automatic logic [4:0] therm2bin(input free_therm_t t);
    logic [4:0] n;
    n = '0;
    for (int k = 1; k <= 16; k++) n = n + {4'd0, t[k]};
    return n;
  endfunction

endpackage

// File: rtl/popcnt16_or_more.sv
// Thermometer population counter: therm_o[k] is high when vec_i has k or more bits set.
module popcnt16_or_more (
  input  logic [15:0] vec_i,
  output logic [16:1] therm_o
);

  logic [4:0] sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < 16; i++) sum = sum + {4'd0, vec_i[i]};
    therm_o = '0;
    for (int k = 1; k <= 16; k++) therm_o[k] = (sum >= 5'(k));
  end

endmodule

// File: rtl/slot_alloc_sched_pick4.sv
// Combinational picker: first cnt_i free slots scanning upward from ptr_i, modulo 16.
module slot_pick4
  import slot_alloc_sched_pkg::*;
(
  input  logic [N_ENTRY-1:0] free_i,
  input  logic [PTR_W-1:0]   ptr_i,
  input  logic [2:0]         cnt_i,
  output logic [N_ENTRY-1:0] gnt_o,
  output logic [PTR_W-1:0]   first_o,
  output logic [PTR_W-1:0]   nxt_ptr_o
);

  logic [2*N_ENTRY-1:0] dbl_free;
  logic [2*N_ENTRY-1:0] dbl_gnt;
  logic [N_ENTRY-1:0]   rot_free;
  logic [N_ENTRY-1:0]   rot_gnt;
  logic [N_ENTRY-1:0]   remain;
  logic [PTR_W-1:0]     hit;
  logic [PTR_W-1:0]     first_idx;
  logic [PTR_W-1:0]     last_idx;

  function automatic logic [PTR_W-1:0] find_first(input logic [N_ENTRY-1:0] v);
    logic [PTR_W-1:0] r;
    r = '0;
    for (int i = N_ENTRY - 1; i >= 0; i--) if (v[i]) r = PTR_W'(i);
    return r;
  endfunction

  always_comb begin
    // Rotate so that bit 0 of rot_free is the slot at ptr_i.
    dbl_free  = {free_i, free_i} >> ptr_i;
    rot_free  = dbl_free[N_ENTRY-1:0];
    remain    = rot_free;
    rot_gnt   = '0;
    hit       = '0;
    first_idx = '0;
    last_idx  = '0;
    for (int s = 0; s < MAX_ALLOC; s++) begin
      hit = find_first(remain);
      if (s == 0) first_idx = hit;
      if (3'(s) < cnt_i) begin
        rot_gnt[hit] = 1'b1;
        remain[hit]  = 1'b0;
        last_idx     = hit;
      end
    end
    dbl_gnt   = {rot_gnt, rot_gnt} << ptr_i;
    gnt_o     = dbl_gnt[2*N_ENTRY-1:N_ENTRY];
    first_o   = ptr_i + first_idx;
    nxt_ptr_o = ptr_i + last_idx + PTR_W'(1);
  end

endmodule

// File: rtl/slot_alloc_sched.sv
// Rotating 0..4-slot allocator over a 16-entry pool with per-cycle release mask,
// registered thermometer/binary free count and sticky double-free flag.
module slot_alloc_sched #(
  parameter int N_ENTRY   = 16,
  parameter int MAX_ALLOC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        alloc_vld,
  input  logic [2:0]  alloc_cnt,
  output logic        alloc_rdy,
  output logic        gnt_vld,
  output logic [15:0] gnt_mask,
  output logic [3:0]  gnt_first,
  input  logic [15:0] rel_mask,
  output logic [4:0]  free_cnt,
  output logic        err_dbl_free
);

  import slot_alloc_sched_pkg::*;

  if (N_ENTRY != 16) begin : g_bad_n_entry
    $error("slot_alloc_sched supports only N_ENTRY = 16");
  end
  if (MAX_ALLOC < 4 || MAX_ALLOC > 16) begin : g_bad_max_alloc
    $error("slot_alloc_sched requires 4 <= MAX_ALLOC <= 16");
  end

  logic [15:0] free_q, free_d;
  logic [3:0]  ptr_q, ptr_d;
  free_therm_t therm_q, therm_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        gnt_vld_q, gnt_vld_d;
  logic [15:0] gnt_mask_q, gnt_mask_d;
  logic [3:0]  gnt_first_q, gnt_first_d;
  logic        err_q, err_d;

  logic        accept;
  logic [2:0]  cnt_eff;
  logic [2:0]  grant_n;
  logic [15:0] pick_mask;
  logic [3:0]  pick_first;
  logic [3:0]  pick_nxt;
  logic [15:0] rel_new;
  free_therm_t rel_therm;
  logic [4:0]  rel_n;
  free_therm_t therm_dn;

  assign accept  = alloc_vld & therm_q[MAX_ALLOC] & ~flush;
  assign cnt_eff = (alloc_cnt > 3'd4) ? 3'd4 : alloc_cnt;
  assign grant_n = accept ? cnt_eff : 3'd0;

  slot_pick4 u_pick (
    .free_i    (free_q),
    .ptr_i     (ptr_q),
    .cnt_i     (grant_n),
    .gnt_o     (pick_mask),
    .first_o   (pick_first),
    .nxt_ptr_o (pick_nxt)
  );

  // Releases of already-free slots are excluded from the count and only flag an error.
  assign rel_new = rel_mask & ~free_q;

  popcnt16_or_more u_rel_cnt (
    .vec_i   (rel_new),
    .therm_o (rel_therm)
  );

  assign rel_n = therm2bin(rel_therm);

  always_comb begin
    free_d      = (free_q & ~pick_mask) | rel_new;
    ptr_d       = ptr_q;
    therm_dn    = therm_q >> grant_n;
    therm_d     = (therm_dn << rel_n) | ~({16{1'b1}} << rel_n);
    cnt_d       = therm2bin(therm_d);
    gnt_vld_d   = accept;
    gnt_mask_d  = accept ? pick_mask : 16'h0000;
    gnt_first_d = accept ? pick_first : gnt_first_q;
    err_d       = err_q | (|(rel_mask & free_q));
    if (accept && (grant_n != 3'd0)) ptr_d = pick_nxt;
    if (flush) begin
      free_d      = '1;
      ptr_d       = '0;
      therm_d     = '1;
      cnt_d       = 5'd16;
      gnt_vld_d   = 1'b0;
      gnt_mask_d  = '0;
      gnt_first_d = '0;
      err_d       = err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_q      <= '1;
      ptr_q       <= '0;
      therm_q     <= '1;
      cnt_q       <= 5'd16;
      gnt_vld_q   <= 1'b0;
      gnt_mask_q  <= '0;
      gnt_first_q <= '0;
      err_q       <= 1'b0;
    end else begin
      free_q      <= free_d;
      ptr_q       <= ptr_d;
      therm_q     <= therm_d;
      cnt_q       <= cnt_d;
      gnt_vld_q   <= gnt_vld_d;
      gnt_mask_q  <= gnt_mask_d;
      gnt_first_q <= gnt_first_d;
      err_q       <= err_d;
    end
  end

  assign alloc_rdy    = therm_q[MAX_ALLOC];
  assign gnt_vld      = gnt_vld_q;
  assign gnt_mask     = gnt_mask_q;
  assign gnt_first    = gnt_first_q;
  assign free_cnt     = cnt_q;
  assign err_dbl_free = err_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) assert ($countones(free_q) == int'(cnt_q));
  end
`endif

endmodule

// File: tb/tb_slot_alloc_sched.sv
// Directed bench for slot_alloc_sched with hand-computed expectations.
module tb_slot_alloc_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        alloc_vld;
  logic [2:0]  alloc_cnt;
  logic        alloc_rdy;
  logic        gnt_vld;
  logic [15:0] gnt_mask;
  logic [3:0]  gnt_first;
  logic [15:0] rel_mask;
  logic [4:0]  free_cnt;
  logic        err_dbl_free;

  int n_cmp = 0;
  int n_bad = 0;

  slot_alloc_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .alloc_vld    (alloc_vld),
    .alloc_cnt    (alloc_cnt),
    .alloc_rdy    (alloc_rdy),
    .gnt_vld      (gnt_vld),
    .gnt_mask     (gnt_mask),
    .gnt_first    (gnt_first),
    .rel_mask     (rel_mask),
    .free_cnt     (free_cnt),
    .err_dbl_free (err_dbl_free)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic f, input logic v, input logic [2:0] c, input logic [15:0] r);
    flush = f; alloc_vld = v; alloc_cnt = c; rel_mask = r;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 3'd0, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt_vld", gnt_vld, 0);
    chk("rst_gnt_mask", gnt_mask, 0);
    chk("rst_gnt_first", gnt_first, 0);
    chk("rst_free_cnt", free_cnt, 16);
    chk("rst_alloc_rdy", alloc_rdy, 1);
    chk("rst_err", err_dbl_free, 0);
    rst_n = 1'b1;

    // Basic 3-slot grant, then pointer at 3
    set_in(1'b0, 1'b1, 3'd3, 16'h0000);
    tick();
    chk("t1_gnt_vld", gnt_vld, 1);
    chk("t1_gnt_mask", gnt_mask, 16'h0007);
    chk("t1_gnt_first", gnt_first, 0);
    chk("t1_free_cnt", free_cnt, 13);
    set_in(1'b0, 1'b0, 3'd0, 16'h0000);
    tick();
    chk("t1_gnt_pulse", gnt_vld, 0);
    set_in(1'b0, 1'b1, 3'd1, 16'h0000);
    tick();
    chk("t1_ptr_mask", gnt_mask, 16'h0008);
    chk("t1_ptr_first", gnt_first, 3);
    chk("t1_ptr_free", free_cnt, 12);
    set_in(1'b0, 1'b1, 3'd0, 16'h0000);
    tick();
    chk("t1_zero_vld", gnt_vld, 1);
    chk("t1_zero_mask", gnt_mask, 16'h0000);
    chk("t1_zero_free", free_cnt, 12);

    // Flush with request pending
    set_in(1'b1, 1'b1, 3'd2, 16'h0000);
    tick();
    chk("fl_gnt_vld", gnt_vld, 0);
    chk("fl_free_cnt", free_cnt, 16);
    chk("fl_alloc_rdy", alloc_rdy, 1);
    set_in(1'b0, 1'b1, 3'd1, 16'h0000);
    tick();
    chk("fl_ptr_mask", gnt_mask, 16'h0001);
    chk("fl_ptr_first", gnt_first, 0);
    chk("fl_ptr_free", free_cnt, 15);

    // Four back-to-back 4-slot grants, fifth held off
    set_in(1'b1, 1'b0, 3'd0, 16'h0000);
    tick();
    set_in(1'b0, 1'b1, 3'd4, 16'h0000);
    tick();
    chk("b2b_mask0", gnt_mask, 16'h000F);
    chk("b2b_free0", free_cnt, 12);
    tick();
    chk("b2b_mask1", gnt_mask, 16'h00F0);
    chk("b2b_free1", free_cnt, 8);
    tick();
    chk("b2b_mask2", gnt_mask, 16'h0F00);
    chk("b2b_rdy2", alloc_rdy, 1);
    tick();
    chk("b2b_mask3", gnt_mask, 16'hF000);
    chk("b2b_free3", free_cnt, 0);
    chk("b2b_rdy3", alloc_rdy, 0);
    tick();
    chk("b2b_held_vld", gnt_vld, 0);
    chk("b2b_held_free", free_cnt, 0);

    // Wrap-around from ptr 14, illegal count 7 treated as 4
    set_in(1'b1, 1'b0, 3'd0, 16'h0000);
    tick();
    set_in(1'b0, 1'b1, 3'd4, 16'h0000);
    repeat (3) tick();
    set_in(1'b0, 1'b1, 3'd2, 16'h0000);
    tick();
    chk("wr_setup_mask", gnt_mask, 16'h3000);
    chk("wr_setup_free", free_cnt, 2);
    chk("wr_setup_rdy", alloc_rdy, 0);
    set_in(1'b0, 1'b0, 3'd0, 16'h3FFF);
    tick();
    chk("wr_rel_free", free_cnt, 16);
    chk("wr_rel_rdy", alloc_rdy, 1);
    set_in(1'b0, 1'b1, 3'd7, 16'h0000);
    tick();
    chk("wr_mask", gnt_mask, 16'hC003);
    chk("wr_first", gnt_first, 14);
    chk("wr_free", free_cnt, 12);
    set_in(1'b0, 1'b1, 3'd1, 16'h0000);
    tick();
    chk("wr_nxt_mask", gnt_mask, 16'h0004);
    chk("wr_nxt_first", gnt_first, 2);

    // Same-cycle release and allocate with free = 0x00F0
    set_in(1'b1, 1'b0, 3'd0, 16'h0000);
    tick();
    set_in(1'b0, 1'b1, 3'd4, 16'h0000);
    repeat (4) tick();
    chk("ra_empty_free", free_cnt, 0);
    set_in(1'b0, 1'b0, 3'd0, 16'h00F0);
    tick();
    chk("ra_setup_free", free_cnt, 4);
    chk("ra_setup_rdy", alloc_rdy, 1);
    set_in(1'b0, 1'b1, 3'd2, 16'h0003);
    tick();
    chk("ra_mask", gnt_mask, 16'h0030);
    chk("ra_first", gnt_first, 4);
    chk("ra_free", free_cnt, 4);
    chk("ra_err", err_dbl_free, 0);
    set_in(1'b0, 1'b1, 3'd2, 16'h0000);
    tick();
    chk("ra_nxt_mask", gnt_mask, 16'h00C0);
    chk("ra_nxt_free", free_cnt, 2);

    // Double free of slot 0, sticky across flush
    set_in(1'b0, 1'b0, 3'd0, 16'h0001);
    tick();
    chk("df_err", err_dbl_free, 1);
    chk("df_free", free_cnt, 2);
    set_in(1'b1, 1'b0, 3'd0, 16'h0000);
    tick();
    chk("df_flush_err", err_dbl_free, 1);
    chk("df_flush_free", free_cnt, 16);
    set_in(1'b0, 1'b0, 3'd0, 16'h0000);
    tick();
    chk("df_hold_err", err_dbl_free, 1);

    // Asynchronous reset mid-allocation
    set_in(1'b0, 1'b1, 3'd3, 16'h0000);
    tick();
    chk("ar_pre_vld", gnt_vld, 1);
    chk("ar_pre_free", free_cnt, 13);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_gnt_vld", gnt_vld, 0);
    chk("ar_gnt_mask", gnt_mask, 0);
    chk("ar_gnt_first", gnt_first, 0);
    chk("ar_free_cnt", free_cnt, 16);
    chk("ar_alloc_rdy", alloc_rdy, 1);
    chk("ar_err", err_dbl_free, 0);
    set_in(1'b0, 1'b0, 3'd0, 16'h0000);
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/slot_alloc_sched.md
Name: slot_alloc_sched

Overview:
- Allocation scheduler for a 16-entry shared slot pool, such as load/store-queue or rename-buffer slots.
- Each cycle it grants 0..4 free slots to one requester, taking them in rotating order from a pointer.
- It accepts an arbitrary release mask every cycle.
- It keeps a registered free-count, in both thermometer and binary form, that drives a registered ready signal. Release counting uses the existing popcount datapath.

Parameters:
- N_ENTRY, 16, pool size. Only 16 is supported; elaboration fails on any other value.
- MAX_ALLOC, 4, maximum slots granted per cycle. alloc_rdy requires at least this many free slots.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pool reset: all slots free, pointer to 0.
- alloc_vld  in  1  allocation request valid.
- alloc_cnt  in  3  number of slots requested, 0..4. Values 5..7 are illegal and are treated as 4.
- alloc_rdy  out  1  registered; high when free count >= MAX_ALLOC.
- gnt_vld  out  1  registered grant valid, one cycle after acceptance.
- gnt_mask  out  16  registered granted-slot mask; popcount equals the accepted alloc_cnt.
- gnt_first  out  4  registered index of the first slot granted, in rotation order.
- rel_mask  in  16  slots released this cycle.
- free_cnt  out  5  registered binary free count, 0..16.
- err_dbl_free  out  1  sticky; a release was made of a slot that is already free.

Behaviour:
- Reset (rst_n low, asynchronous) sets:
  - free bitmap = all ones, ptr = 0, free_therm[16:1] = all ones;
  - free_cnt = 16, alloc_rdy = 1;
  - gnt_vld = 0, gnt_mask = 0, gnt_first = 0, err_dbl_free = 0.
- Acceptance:
  - A request is accepted when alloc_vld & alloc_rdy & ~flush.
  - An accepted request with alloc_cnt = 0 produces gnt_vld = 1 with gnt_mask = 0, and no state change.
- Slot selection:
  - Scan from ptr upward, modulo 16, and pick the first alloc_cnt slots whose free bit is set.
  - alloc_rdy guarantees at least 4 free slots, so the pick always succeeds.
- Latency:
  - The grant is registered and visible on gnt_* in cycle T+1 for acceptance in cycle T.
  - gnt_vld lasts one cycle. There is no backpressure on the grant; the consumer must take it.
  - Granted slots are cleared in the free bitmap at the T edge.
- Pointer:
  - After a non-zero grant, ptr = (index of the last granted slot + 1) mod 16.
  - ptr is unchanged otherwise.
- Release:
  - Slots in rel_mask are set free at the clock edge.
  - A slot released in cycle T is not eligible for the pick in cycle T; it becomes eligible in T+1.
- Simultaneous allocate and release:
  - Next free count = free_cnt - granted + popcount(rel_mask & ~free).
  - The thermometer free_therm is updated by shift-down by the grant count and shift-up by the release count.
  - free_cnt is the binary encoding of free_therm.
  - alloc_rdy in the next cycle = next free_therm[4].
- Double free:
  - Any rel_mask bit set on an already-free slot sets err_dbl_free, which stays set until reset.
  - Those bits are ignored when counting.
- Flush:
  - Takes priority over alloc and release in the same cycle.
  - Next state equals the reset state, except err_dbl_free, which is held.
  - gnt_vld in the cycle after a flush is 0, even if alloc_vld was high.
- Wrap-around:
  - A pick that crosses slot 15 continues at slot 0. The gnt_mask bits are non-contiguous in that case.
- Invariant (assert): popcount(free bitmap) == free_cnt in every cycle.

Decomposition:
- Shared package holds:
  - constants N_ENTRY = 16, MAX_ALLOC = 4, PTR_W = 4;
  - the free-count thermometer type [16:1].
- Sub-module slot_pick4 (combinational):
  - inputs: free bitmap, ptr, count;
  - outputs: grant mask, first index, next ptr;
  - implementation: rotate, four cascaded priority-find stages, rotate back.
- Release counting reuses the existing popcnt16_or_more thermometer counter on (rel_mask & ~free).

Test Plan:
1. Reset, then alloc_vld = 1, alloc_cnt = 3 in cycle 0 -> in cycle 1:
   - gnt_vld = 1, gnt_mask = 0x0007, gnt_first = 0;
   - free_cnt = 13, ptr = 3.
2. Four back-to-back alloc_cnt = 4 requests from reset -> grants 0x000F, 0x00F0, 0x0F00, 0xF000. alloc_rdy falls in the cycle after the last acceptance (free_cnt = 0), and a fifth request is held off.
3. Wrap-around with ptr = 14, all slots free, alloc_cnt = 4 -> gnt_mask = 0xC003, gnt_first = 14, next ptr = 2.
4. Release and allocate in the same cycle:
   - Setup: free = 0x00F0 only (free_cnt = 4).
   - Stimulus: rel_mask = 0x0003 together with alloc_cnt = 2.
   - Required: gnt_mask takes slots from 0x00F0 only, never 0x0003; free_cnt = 4.
5. rel_mask = 0x0001 while slot 0 is free -> err_dbl_free = 1 and stays set after flush; free_cnt is unchanged.
6. Flush and reset:
   - flush asserted with alloc_vld high -> gnt_vld = 0 next cycle, free_cnt = 16, ptr = 0.
   - rst_n pulsed low mid-allocation (asynchronously) -> all outputs reach reset values immediately.
